frame_write_arbiter: RTL

// Sole owner of the frameRAM write port. Serialises 4-bit trail-pixel writes from the red and

---
 rtl/frame_write_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/frame_write_arbiter.sv
// Single owner of the frameRAM write port: read-modify-write of 4-bit trail pixels from the
// red and blue bike engines, trail/wall collision reporting, and a full-screen clear sweep.
module frame_write_arbiter #(
   parameter int unsigned H_RES      = 640,
   parameter int unsigned V_RES      = 480,
   parameter logic [3:0]  BG_COLOR   = 4'h0,
   parameter logic [15:0] CLEAR_WORD = 16'h0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        clear_start,
   output logic        clear_busy,
   input  logic        red_req,
   input  logic [9:0]  red_x,
   input  logic [9:0]  red_y,
   input  logic [3:0]  red_color,
   output logic        red_ack,
   output logic        red_hit,
   input  logic        blue_req,
   input  logic [9:0]  blue_x,
   input  logic [9:0]  blue_y,
   input  logic [3:0]  blue_color,
   output logic        blue_ack,
   output logic        blue_hit,
   output logic [18:0] fb_rd_addr,
   input  logic [15:0] fb_rd_data,
   output logic        fb_we,
   output logic [18:0] fb_wr_addr,
   output logic [15:0] fb_wr_data
);

   localparam int unsigned NUM_WORDS = H_RES * V_RES / 2;
   localparam logic [18:0] LAST_ADDR = 19'(NUM_WORDS - 1);
   localparam logic [10:0] H_LIM     = 11'(H_RES);
   localparam logic [10:0] V_LIM     = 11'(V_RES);

   typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, CLEAR} state_t;

   state_t      state;
   logic        last_blue;
   logic        gnt_blue;
   logic        oor_q;
   logic        odd_q;
   logic [3:0]  color_q;
   logic [18:0] addr_q;
   logic [15:0] merged_q;
   logic        hit_q;
   logic        clear_pend;

   logic        pick_blue;
   logic [9:0]  sel_x;
   logic [9:0]  sel_y;
   logic [3:0]  sel_color;
   logic        sel_oor;
   logic [18:0] sel_addr;
   logic [3:0]  cur_nib;
   logic [15:0] merged;

   // For the 640-wide screen y*320 is (y<<8)+(y<<6); other widths fall back to a constant multiply.
   function automatic logic [18:0] word_addr(input logic [9:0] px, input logic [9:0] py);
      logic [18:0] y19;
      y19 = {9'd0, py};
      if (H_RES == 640)
         return (y19 << 8) + (y19 << 6) + {10'd0, px[9:1]};
      else
         return 19'(py * (H_RES / 2)) + {10'd0, px[9:1]};
   endfunction

   // Round-robin: on a tie the requester that was not granted last wins.
   always_comb begin
      pick_blue = blue_req && (!red_req || !last_blue);
      sel_x     = pick_blue ? blue_x     : red_x;
      sel_y     = pick_blue ? blue_y     : red_y;
      sel_color = pick_blue ? blue_color : red_color;
      sel_oor   = ({1'b0, sel_x} >= H_LIM) || ({1'b0, sel_y} >= V_LIM);
      sel_addr  = word_addr(sel_x, sel_y);
   end

   always_comb begin
      cur_nib = odd_q ? fb_rd_data[11:8] : fb_rd_data[3:0];
      merged  = fb_rd_data;
      if (odd_q)
         merged[11:8] = color_q;
      else
         merged[3:0]  = color_q;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         last_blue  <= 1'b1;
         gnt_blue   <= 1'b0;
         oor_q      <= 1'b0;
         odd_q      <= 1'b0;
         color_q    <= '0;
         addr_q     <= '0;
         merged_q   <= '0;
         hit_q      <= 1'b0;
         clear_pend <= 1'b0;
         clear_busy <= 1'b0;
         red_ack    <= 1'b0;
         red_hit    <= 1'b0;
         blue_ack   <= 1'b0;
         blue_hit   <= 1'b0;
         fb_rd_addr <= '0;
         fb_we      <= 1'b0;
         fb_wr_addr <= '0;
         fb_wr_data <= '0;
      end else begin
         red_ack  <= 1'b0;
         red_hit  <= 1'b0;
         blue_ack <= 1'b0;
         blue_hit <= 1'b0;
         fb_we    <= 1'b0;

         if (clear_start && (state == READ || state == CHECK || state == WRITE))
            clear_pend <= 1'b1;

         case (state)
            IDLE: begin
               if (clear_start || clear_pend) begin
                  state      <= CLEAR;
                  clear_pend <= 1'b0;
                  clear_busy <= 1'b1;
                  fb_we      <= 1'b1;
                  fb_wr_addr <= '0;
                  fb_wr_data <= CLEAR_WORD;
               end else if (red_req || blue_req) begin
                  state     <= READ;
                  gnt_blue  <= pick_blue;
                  last_blue <= pick_blue;
                  oor_q     <= sel_oor;
                  odd_q     <= sel_x[0];
                  color_q   <= sel_color;
                  addr_q    <= sel_addr;
                  if (!sel_oor)
                     fb_rd_addr <= sel_addr;
               end
            end

            // Off-screen targets retire here as a wall hit without touching memory.
            READ: begin
               if (oor_q) begin
                  red_ack  <= ~gnt_blue;
                  red_hit  <= ~gnt_blue;
                  blue_ack <= gnt_blue;
                  blue_hit <= gnt_blue;
                  state    <= IDLE;
               end else begin
                  state <= CHECK;
               end
            end

            CHECK: begin
               hit_q    <= (cur_nib != BG_COLOR);
               merged_q <= merged;
               state    <= WRITE;
            end

            WRITE: begin
               fb_we      <= 1'b1;
               fb_wr_addr <= addr_q;
               fb_wr_data <= merged_q;
               red_ack    <= ~gnt_blue;
               red_hit    <= ~gnt_blue & hit_q;
               blue_ack   <= gnt_blue;
               blue_hit   <= gnt_blue & hit_q;
               state      <= IDLE;
            end

            CLEAR: begin
               if (fb_wr_addr == LAST_ADDR) begin
                  clear_busy <= 1'b0;
                  state      <= IDLE;
               end else begin
                  fb_we      <= 1'b1;
                  fb_wr_addr <= fb_wr_addr + 19'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
